// File: rtl/wb_irq_pkg.sv
// wb_irq_pkg
//   Shared definitions for the Wishbone external interrupt controller:
//   register word offsets (byte address bits [4:2]), FSM state encoding
//   and STATUS register bit positions.
package wb_irq_pkg;

    localparam int IRQ_ID_W = 5;

    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ENABLE  = 3'd1;
    localparam logic [2:0] IRQ_TRIGGER = 3'd2;
    localparam logic [2:0] IRQ_CLAIM   = 3'd3;
    localparam logic [2:0] IRQ_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACKED   = 2'd2,
        SERVICE = 2'd3
    } irq_state_t;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_STATE_MSB = 1;
    localparam int STATUS_BAD_BIT   = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge
//   Multi-flop synchroniser for WIDTH asynchronous interrupt lines plus a
//   rising-edge detector on the synchronised value.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     raw    asynchronous input lines
//     level  synchronised lines (output of the last stage)
//     rise   one-cycle pulse on each 0->1 transition of level
module irq_sync_edge
    import wb_irq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                chain[k] <= '0;
            end
            level_d <= '0;
        end else begin
            chain[0] <= raw;
            for (int k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
            level_d <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~level_d;

endmodule

// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl
//   External interrupt controller on Wishbone. Synchronises NUM_SRC
//   peripheral lines, latches them as level or edge pending, masks with
//   ENABLE, picks the lowest-numbered eligible source and drives meip_o.
//   The trap handler reads CLAIM to get the source ID and writes it back
//   to CLAIM/COMPLETE to retire it.
//   Ports:
//     clk_i, reset_i   clock, asynchronous active-low reset
//     irq_src_i        raw peripheral interrupt lines (asynchronous)
//     irq_ack_i        core interrupt-taken pulse
//     meip_o           machine external interrupt request (registered)
//     wb_*             Wishbone slave, one-cycle ack after each request
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | nothing eligible, meip_o low
//   REQ     | eligible source present, meip_o high, waiting for core
//   ACKED   | core took the trap, waiting for the claim read
//   SERVICE | source claimed, waiting for matching complete write
module wb_irq_ctrl
    import wb_irq_pkg::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               irq_ack_i,
    output logic               meip_o,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [4:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o
);

    logic [NUM_SRC-1:0] src_level;
    logic [NUM_SRC-1:0] src_rise;

    irq_sync_edge #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (reset_i),
        .raw   (irq_src_i),
        .level (src_level),
        .rise  (src_rise)
    );

    logic [NUM_SRC-1:0]  pending_q;
    logic [NUM_SRC-1:0]  pending_nxt;
    logic [NUM_SRC-1:0]  enable_q;
    logic [NUM_SRC-1:0]  trigger_q;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  win_onehot;
    logic [NUM_SRC-1:0]  claim_clr;
    logic [NUM_SRC-1:0]  w1c_clr;
    logic [IRQ_ID_W-1:0] win_id;
    logic [IRQ_ID_W-1:0] claimed_id_q;
    irq_state_t          state_q;
    irq_state_t          state_nxt;
    logic                bad_q;
    logic                meip_q;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [31:0]         rdata;

    logic       req;
    logic       wr;
    logic       rd;
    logic [2:0] word;
    logic       claim_rd;
    logic       complete_wr;
    logic       complete_ok;
    logic       unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr          = req & wb_we_i & (wb_sel_i == 4'hF);
    assign rd          = req & ~wb_we_i;
    assign word        = wb_adr_i[4:2];
    assign claim_rd    = rd & (word == IRQ_CLAIM);
    assign complete_wr = wr & (word == IRQ_CLAIM);
    assign complete_ok = complete_wr & (wb_dat_i == 32'(claimed_id_q));

    assign eligible = pending_q & enable_q;

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        win_id     = '0;
        win_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id        = IRQ_ID_W'(i + 1);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Only edge sources hold state; a new edge in the same cycle as a
    // clear keeps the bit set so the event is not lost.
    assign claim_clr   = claim_rd ? (win_onehot & trigger_q) : '0;
    assign w1c_clr     = (wr && word == IRQ_PENDING) ? (wb_dat_i[NUM_SRC-1:0] & trigger_q) : '0;
    assign pending_nxt = (trigger_q & (src_rise | (pending_q & ~(claim_clr | w1c_clr))))
                       | (~trigger_q & src_level);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (eligible != '0) state_nxt = REQ;
            end
            REQ: begin
                if (claim_rd && win_id != '0) state_nxt = SERVICE;
                else if (eligible == '0)      state_nxt = IDLE;
                else if (irq_ack_i)           state_nxt = ACKED;
            end
            ACKED: begin
                if (claim_rd) state_nxt = (win_id != '0) ? SERVICE : IDLE;
            end
            SERVICE: begin
                if (complete_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (word)
            IRQ_PENDING: rdata = 32'(pending_q);
            IRQ_ENABLE:  rdata = 32'(enable_q);
            IRQ_TRIGGER: rdata = 32'(trigger_q);
            IRQ_CLAIM:   rdata = 32'(win_id);
            IRQ_STATUS: begin
                rdata[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_q;
                rdata[STATUS_BAD_BIT]                    = bad_q;
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            meip_q       <= 1'b0;
            pending_q    <= '0;
            enable_q     <= '0;
            trigger_q    <= '0;
            claimed_id_q <= '0;
            bad_q        <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            state_q   <= state_nxt;
            meip_q    <= (state_nxt == REQ);
            pending_q <= pending_nxt;
            ack_q     <= req;
            dat_q     <= rd ? rdata : '0;

            // Claims outside REQ/ACKED are informational and must not
            // disturb the ID the handler is about to complete.
            if (claim_rd && win_id != '0 && (state_q == REQ || state_q == ACKED)) begin
                claimed_id_q <= win_id;
            end

            if (wr && word == IRQ_ENABLE)  enable_q  <= wb_dat_i[NUM_SRC-1:0];
            if (wr && word == IRQ_TRIGGER) trigger_q <= wb_dat_i[NUM_SRC-1:0];

            if (complete_wr && !complete_ok) begin
                bad_q <= 1'b1;
            end else if (wr && word == IRQ_STATUS && wb_dat_i[STATUS_BAD_BIT]) begin
                bad_q <= 1'b0;
            end
        end
    end

    assign meip_o   = meip_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
module tb_wb_irq_ctrl;

    localparam int NUM_SRC = 16;

    localparam logic [4:0] A_PEND = 5'h00;
    localparam logic [4:0] A_EN   = 5'h04;
    localparam logic [4:0] A_TRIG = 5'h08;
    localparam logic [4:0] A_CLM  = 5'h0C;
    localparam logic [4:0] A_STAT = 5'h10;
    localparam logic [4:0] A_NONE = 5'h14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_src;
    logic               irq_ack;
    logic               meip;
    logic               wb_cyc;
    logic               wb_stb;
    logic               wb_we;
    logic [4:0]         wb_adr;
    logic [31:0]        wb_wdat;
    logic [3:0]         wb_sel;
    logic [31:0]        wb_rdat;
    logic               wb_ack;

    int n_tests = 0;
    int n_fail  = 0;

    wb_irq_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst_n),
        .irq_src_i (irq_src),
        .irq_ack_i (irq_ack),
        .meip_o    (meip),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_wdat),
        .wb_sel_i  (wb_sel),
        .wb_dat_o  (wb_rdat),
        .wb_ack_o  (wb_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = 1'b1;
        wb_adr  = adr;
        wb_wdat = dat;
        wb_sel  = sel;
        tick(1);
        check("write ack", 32'(wb_ack), 32'd1);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        wb_sel = 4'h0;
        tick(1);
    endtask

    task automatic wb_read_check(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = adr;
        tick(1);
        check({tag, " ack"}, 32'(wb_ack), 32'd1);
        check(tag, wb_rdat, exp);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        tick(1);
    endtask

    initial begin
        int acks;
        rst_n   = 1'b0;
        irq_src = '0;
        irq_ack = 1'b0;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        wb_we   = 1'b0;
        wb_adr  = '0;
        wb_wdat = '0;
        wb_sel  = '0;

        // reset values
        #12;
        check("reset meip", 32'(meip), 32'd0);
        check("reset ack", 32'(wb_ack), 32'd0);
        check("reset dat", wb_rdat, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        wb_read_check("reset enable", A_EN, 32'h0);
        wb_read_check("reset trigger", A_TRIG, 32'h0);
        wb_read_check("reset status", A_STAT, 32'h0);
        wb_read_check("reset pending", A_PEND, 32'h0);

        // register access rules
        wb_write(A_EN, 32'hFFFF_FFFF, 4'hF);
        wb_read_check("enable upper bits", A_EN, 32'h0000_FFFF);
        wb_write(A_EN, 32'h0000_1234, 4'h3);
        wb_read_check("partial sel ignored", A_EN, 32'h0000_FFFF);
        wb_read_check("unmapped offset", A_NONE, 32'h0);
        wb_write(A_EN, 32'h0, 4'hF);

        // held request acks every other cycle
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = A_EN;
        acks   = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (wb_ack) acks++;
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        tick(1);
        check("back-to-back acks", 32'(acks), 32'd2);

        // edge source 0: latency, claim, complete
        wb_write(A_TRIG, 32'h1, 4'hF);
        wb_write(A_EN, 32'h1, 4'hF);
        irq_src[0] = 1'b1;
        tick(1);
        irq_src[0] = 1'b0;
        tick(2);
        check("edge meip not yet", 32'(meip), 32'd0);
        tick(1);
        check("edge meip at 4", 32'(meip), 32'd1);
        wb_read_check("edge status req", A_STAT, 32'h1);
        wb_read_check("edge claim", A_CLM, 32'h1);
        check("edge meip after claim", 32'(meip), 32'd0);
        wb_read_check("edge pending cleared", A_PEND, 32'h0);
        wb_read_check("edge status service", A_STAT, 32'h3);
        wb_write(A_CLM, 32'h1, 4'hF);
        wb_read_check("edge status idle", A_STAT, 32'h0);
        tick(3);
        check("edge meip stays low", 32'(meip), 32'd0);

        // priority with level sources 3 and 7
        wb_write(A_TRIG, 32'h0, 4'hF);
        wb_write(A_EN, 32'h0, 4'hF);
        irq_src = 16'h0088;
        tick(6);
        check("disabled no meip", 32'(meip), 32'd0);
        wb_read_check("level pending", A_PEND, 32'h88);
        wb_read_check("disabled status idle", A_STAT, 32'h0);
        wb_write(A_EN, 32'h88, 4'hF);
        check("prio meip", 32'(meip), 32'd1);
        wb_read_check("prio claim 4", A_CLM, 32'h4);
        irq_src = 16'h0080;
        tick(4);
        wb_write(A_CLM, 32'h4, 4'hF);
        check("prio meip again", 32'(meip), 32'd1);
        wb_read_check("prio claim 8", A_CLM, 32'h8);
        irq_src = 16'h0000;
        tick(4);
        wb_write(A_CLM, 32'h8, 4'hF);
        wb_read_check("prio status idle", A_STAT, 32'h0);
        check("prio meip low", 32'(meip), 32'd0);

        // handshake through ACKED and a bad complete
        irq_src = 16'h0008;
        tick(5);
        check("hs meip", 32'(meip), 32'd1);
        wb_read_check("hs status req", A_STAT, 32'h1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("hs meip after ack", 32'(meip), 32'd0);
        wb_read_check("hs status acked", A_STAT, 32'h2);
        wb_read_check("hs claim", A_CLM, 32'h4);
        wb_read_check("hs status service", A_STAT, 32'h3);
        wb_write(A_CLM, 32'h5, 4'hF);
        wb_read_check("hs bad complete", A_STAT, 32'h103);
        irq_src = 16'h0000;
        tick(4);
        wb_write(A_CLM, 32'h4, 4'hF);
        wb_read_check("hs good complete", A_STAT, 32'h100);
        wb_write(A_STAT, 32'h100, 4'hF);
        wb_read_check("hs bad flag cleared", A_STAT, 32'h0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        wb_read_check("ack in idle ignored", A_STAT, 32'h0);

        // level drop before ack
        wb_write(A_EN, 32'h4, 4'hF);
        irq_src = 16'h0004;
        tick(5);
        check("drop meip high", 32'(meip), 32'd1);
        irq_src = 16'h0000;
        tick(5);
        check("drop meip low", 32'(meip), 32'd0);
        wb_read_check("drop status idle", A_STAT, 32'h0);
        wb_read_check("drop claim zero", A_CLM, 32'h0);

        // W1C colliding with a new edge
        wb_write(A_TRIG, 32'h1, 4'hF);
        wb_write(A_EN, 32'h0, 4'hF);
        irq_src[0] = 1'b1;
        tick(1);
        irq_src[0] = 1'b0;
        tick(4);
        wb_read_check("w1c before", A_PEND, 32'h1);
        wb_write(A_PEND, 32'h1, 4'hF);
        wb_read_check("w1c cleared", A_PEND, 32'h0);
        irq_src[0] = 1'b1;
        tick(1);
        irq_src[0] = 1'b0;
        tick(1);
        wb_write(A_PEND, 32'h1, 4'hF);
        wb_read_check("collision set wins", A_PEND, 32'h1);

        // asynchronous reset in SERVICE during a read ack
        wb_write(A_EN, 32'h1, 4'hF);
        tick(1);
        wb_read_check("rst claim", A_CLM, 32'h1);
        wb_read_check("rst status service", A_STAT, 32'h3);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = A_EN;
        tick(1);
        check("rst pre ack", 32'(wb_ack), 32'd1);
        check("rst pre dat", wb_rdat, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async meip", 32'(meip), 32'd0);
        check("rst async ack", 32'(wb_ack), 32'd0);
        check("rst async dat", wb_rdat, 32'd0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        wb_read_check("post rst enable", A_EN, 32'h0);
        wb_read_check("post rst trigger", A_TRIG, 32'h0);
        wb_read_check("post rst status", A_STAT, 32'h0);
        wb_read_check("post rst pending", A_PEND, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- External interrupt controller that sits on the Wishbone bus next to wb_top.
- Drives the core's meip_i line and consumes its irq_ack_o.
- Synchronises NUM_SRC peripheral interrupt lines, latches them per source as level- or edge-triggered, and applies per-source enables.
- Exposes claim/complete registers so the trap handler identifies and retires the interrupt.

Parameters:
- NUM_SRC, 16, number of external interrupt sources (1..31).
- SYNC_STAGES, 2, flip-flop stages on each irq_src_i bit.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-low reset.
- irq_src_i  input  NUM_SRC  raw peripheral interrupt lines, asynchronous to clk_i.
- irq_ack_i  input  1  core interrupt-taken pulse (core irq_ack_o).
- meip_o  output  1  machine external interrupt request to the core (core meip_i).
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe.
- wb_we_i  input  1  Wishbone write enable.
- wb_adr_i  input  5  byte address; bits [1:0] ignored.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte selects; a write is honoured only when wb_sel_i = 4'hF.
- wb_dat_o  output  32  read data.
- wb_ack_o  output  1  Wishbone acknowledge.

Behaviour:
- Reset (reset_i=0, asynchronous): meip_o=0, wb_ack_o=0, wb_dat_o=0, PENDING=0, ENABLE=0, TRIGGER=0 (all level), FSM=IDLE, claimed_id=0, synchroniser flops=0.
- Synchroniser: each irq_src_i bit passes through SYNC_STAGES flops, giving s. Edge detect is s & ~s_d (s_d is s delayed one cycle).
- Pending, level source: PENDING[i] = s[i]. Writes to it are ignored.
- Pending, edge source: rising edge sets PENDING[i]. Writing 1 to PENDING[i] clears it. Claim clears it.
- If a set and a clear hit the same bit in the same cycle, set wins.
- Eligible = PENDING & ENABLE.
- Winner = lowest-numbered eligible source. ID = index+1; ID 0 means none.
- Register map (word offsets):
  - 0x00 PENDING: RO for level sources, W1C for edge sources.
  - 0x04 ENABLE: RW.
  - 0x08 TRIGGER: RW, 1 = edge.
  - 0x0C CLAIM/COMPLETE: read = claim, write = complete.
  - 0x10 STATUS: [1:0] FSM state, [8] sticky bad-complete flag, cleared by writing 1.
  - Other offsets: read 0, writes ignored.
  - Bits at or above NUM_SRC read 0.
- Wishbone timing:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o is a one-cycle pulse the cycle after a request; wb_dat_o is valid in that same cycle.
  - Back-to-back requests therefore get an ack every other cycle.
  - Register side effects take effect on the request cycle.
- FSM:
  - IDLE (meip_o=0): Eligible≠0 -> REQ.
  - REQ (meip_o=1):
    - Eligible becomes 0 (level line dropped or source disabled) -> IDLE.
    - irq_ack_i=1 -> ACKED.
    - Claim read with nonzero winner -> SERVICE.
    - If irq_ack_i and a claim occur in the same cycle, SERVICE wins.
  - ACKED (meip_o=0): claim read with nonzero winner -> SERVICE; a claim returning 0 -> IDLE.
  - SERVICE (meip_o=0): a COMPLETE write whose data equals claimed_id -> IDLE.
- Claim read:
  - Returns the winner ID and latches claimed_id.
  - If the winner is an edge source, its PENDING bit is cleared in the same cycle.
  - If Eligible=0, returns 0 and has no side effect.
  - A claim read in IDLE or SERVICE returns the ID but does not change state or claimed_id.
- COMPLETE write with a non-matching ID: ignored, sets STATUS[8], FSM stays in SERVICE.
- meip_o is registered. Latency from an irq_src_i edge to meip_o=1 is SYNC_STAGES+2 cycles (+1 edge detect, +1 FSM register).
- irq_ack_i outside REQ is ignored.

Decomposition:
- Shared package wb_irq_pkg holds:
  - register offset constants IRQ_PENDING/IRQ_ENABLE/IRQ_TRIGGER/IRQ_CLAIM/IRQ_STATUS;
  - FSM state encoding IDLE=0, REQ=1, ACKED=2, SERVICE=3;
  - STATUS bit positions.
- One sub-module, irq_sync_edge: the NUM_SRC-wide synchroniser plus rising-edge detector.
- Priority encoder and Wishbone slave stay in the top module.

Test Plan:
- Edge source: TRIGGER=0x0001, ENABLE=0x0001; pulse irq_src_i[0] for 1 cycle -> meip_o=1 after 4 cycles; claim reads 1; PENDING=0; COMPLETE write 1 -> FSM IDLE, meip_o stays 0.
- Priority: sources 3 and 7 pending and enabled -> claim returns 4, then after complete returns 8; lines set with ENABLE=0 never raise meip_o.
- Handshake: in REQ, pulse irq_ack_i -> meip_o=0 next cycle, STATUS[1:0]=2; claim -> STATUS=3; COMPLETE write 5 while claimed_id=4 -> STATUS[8]=1, state still 3.
- Level drop: level source 2 asserted, then deasserted before ack -> meip_o returns 0, FSM IDLE, claim reads 0.
- Collision/reset: W1C of bit 0 in the same cycle as a new edge on source 0 -> PENDING[0]=1. Drive reset_i=0 mid-SERVICE -> all outputs 0 immediately; ENABLE reads 0 after release.
